// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer: state encoding,
// field limits and the {milis, micros, nanos} time triple.
package countdown_timer_pkg;

  localparam int FW         = 10;
  localparam int NS_MAX_DEF = 999;
  localparam int US_MAX_DEF = 999;
  localparam int MS_MAX     = 999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [FW-1:0] ms;
    logic [FW-1:0] us;
    logic [FW-1:0] ns;
  } time_t;

  function automatic logic [FW-1:0] sat(input logic [FW-1:0] v, input logic [FW-1:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master drives the load
// and control inputs, slave (the timer) returns status and remaining time.
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  logic          start;
  logic          cancel;
  logic [FW-1:0] load_milis;
  logic [FW-1:0] load_micros;
  logic          busy;
  logic          expired;
  logic          done;
  logic [FW-1:0] rem_milis;
  logic [FW-1:0] rem_micros;
  logic [FW-1:0] rem_nanos;

  modport master (
    output start, cancel, load_milis, load_micros,
    input  busy, expired, done, rem_milis, rem_micros, rem_nanos
  );

  modport slave (
    input  start, cancel, load_milis, load_micros,
    output busy, expired, done, rem_milis, rem_micros, rem_nanos
  );

endinterface

// File: rtl/countdown_timer_time_decrement.sv
// Combinational borrow-chain decrement of a time triple by one nanos unit.
// zero flags that the result is zero; a zero input holds at zero.
module time_decrement
  import countdown_timer_pkg::*;
#(
  parameter int NS_MAX = NS_MAX_DEF,
  parameter int US_MAX = US_MAX_DEF
) (
  input  time_t cur,
  output time_t nxt,
  output logic  zero
);

  always_comb begin
    nxt = cur;
    if (cur.ns != '0) begin
      nxt.ns = cur.ns - 1'b1;
    end else if (cur.us != '0) begin
      nxt.ns = FW'(NS_MAX);
      nxt.us = cur.us - 1'b1;
    end else if (cur.ms != '0) begin
      nxt.ns = FW'(NS_MAX);
      nxt.us = FW'(US_MAX);
      nxt.ms = cur.ms - 1'b1;
    end
    zero = (nxt == '0);
  end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer over a {milis, micros, nanos} triple, one nanos per CLK edge.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN for periodic mode (reload on expiry).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int NS_MAX = NS_MAX_DEF,
  parameter int US_MAX = US_MAX_DEF
) (
  input logic          CLK,
  input logic          reset,
  countdown_timer_if.slave bus
);

  state_t state, state_nxt;
  time_t  rem, rem_dec, load_val, exp_val;
  logic   rem_zero;
  logic   expired_q;

  always_comb begin
    load_val.ms = sat(bus.load_milis, FW'(MS_MAX));
    load_val.us = sat(bus.load_micros, FW'(US_MAX));
    load_val.ns = '0;
  end

  time_decrement #(.NS_MAX(NS_MAX), .US_MAX(US_MAX)) u_dec (
    .cur  (rem),
    .nxt  (rem_dec),
    .zero (rem_zero)
  );

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
  time_t reload;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)         reload <= '0;
    else if (bus.start) reload <= load_val;
  end

  assign exp_val = reload;
`else
  localparam bit AUTO = 1'b0;
  assign exp_val = '0;
`endif

  // state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state; start outranks cancel so a simultaneous pair restarts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.start)       state_nxt = RUN;
        else if (bus.cancel) state_nxt = IDLE;
        else if (rem_zero)   state_nxt = AUTO ? RUN : DONE;
      end
      DONE: begin
        if (bus.start)       state_nxt = RUN;
        else if (bus.cancel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // remaining time and expiry pulse; the edge that takes rem to zero expires
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.start) begin
        rem <= load_val;
      end else if (state == RUN && !bus.cancel) begin
        if (rem_zero) begin
          expired_q <= 1'b1;
          rem       <= exp_val;
        end else begin
          rem <= rem_dec;
        end
      end else begin
        rem <= '0;
      end
    end
  end

  assign bus.expired    = expired_q;
  assign bus.rem_milis  = rem.ms;
  assign bus.rem_micros = rem.us;
  assign bus.rem_nanos  = rem.ns;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expiry events are queued at stimulus
// time and matched by a monitor against each observed expired pulse.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  typedef struct {
    int   cyc;
    logic done;
    logic busy;
  } exp_t;

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e_mon;
  int   s;

  countdown_timer_if bus();

  countdown_timer #(.NS_MAX(999), .US_MAX(999)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // returns the index of the edge that sampled start
  task automatic do_start(input logic [9:0] ms, input logic [9:0] us,
                          input logic with_cancel, output int edge_i);
    bus.load_milis  = ms;
    bus.load_micros = us;
    bus.start       = 1'b1;
    bus.cancel      = with_cancel;
    @(negedge CLK);
    edge_i     = cyc;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    @(negedge CLK);
    bus.cancel = 1'b0;
  endtask

  task automatic expect_at(input int c, input logic d, input logic b);
    exp_t e;
    e.cyc  = c;
    e.done = d;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    int'(bus.busy),    0);
    chk({tag, "_done"},    int'(bus.done),    0);
    chk({tag, "_expired"}, int'(bus.expired), 0);
    chk({tag, "_milis"},   int'(bus.rem_milis),  0);
    chk({tag, "_micros"},  int'(bus.rem_micros), 0);
    chk({tag, "_nanos"},   int'(bus.rem_nanos),  0);
  endtask

  always @(negedge CLK) begin
    if (bus.expired === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_expired: pulse at cyc %0d, required none", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("expired_cyc", cyc, e_mon.cyc);
        chk("done_at_expiry", int'(bus.done), int'(e_mon.done));
        chk("busy_at_expiry", int'(bus.busy), int'(e_mon.busy));
      end
    end
  end

  initial begin
    bus.start       = 1'b0;
    bus.cancel      = 1'b0;
    bus.load_milis  = '0;
    bus.load_micros = '0;
    step(3);
    chk_idle("reset");

    // release and start on the very first edge after release: 2 us
    reset = 1'b1;
    do_start(10'd0, 10'd2, 1'b0, s);
    chk("load_micros", int'(bus.rem_micros), 2);
    chk("load_nanos",  int'(bus.rem_nanos),  0);
    chk("load_busy",   int'(bus.busy),       1);
    expect_at(s + 2000, 1'b1, 1'b0);
    step(2005);
    chk("after2us_done",  int'(bus.done),      1);
    chk("after2us_busy",  int'(bus.busy),      0);
    chk("after2us_micros", int'(bus.rem_micros), 0);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    do_start(10'd0, 10'd1, 1'b0, s);
    expect_at(s + 1000, 1'b0, 1'b1);
    expect_at(s + 2000, 1'b0, 1'b1);
    expect_at(s + 3000, 1'b0, 1'b1);
    step(3050);
    chk("auto_done", int'(bus.done), 0);
    chk("auto_busy", int'(bus.busy), 1);
    do_cancel();
    chk_idle("auto_cancel");
    step(1100);
`else
    // restart at edge +500 with 3 us: the first count never expires
    do_start(10'd0, 10'd1, 1'b0, s);
    step(499);
    do_start(10'd0, 10'd3, 1'b0, s);
    expect_at(s + 3000, 1'b1, 1'b0);
    step(3100);

    // start and cancel together: start wins
    do_start(10'd0, 10'd1, 1'b1, s);
    chk("start_cancel_busy", int'(bus.busy), 1);
    expect_at(s + 1000, 1'b1, 1'b0);
    step(1100);

    // cancel mid-count
    do_start(10'd0, 10'd1, 1'b0, s);
    step(300);
    do_cancel();
    chk_idle("cancel");
    step(1000);

    // reset mid-count discards it
    do_start(10'd0, 10'd1, 1'b0, s);
    step(699);
    reset = 1'b0;
    step(2);
    chk_idle("midreset");
    reset = 1'b1;
    step(5000);

    // zero duration expires on the first following edge
    do_start(10'd0, 10'd0, 1'b0, s);
    expect_at(s + 1, 1'b1, 1'b0);
    step(5);

    // over-range loads saturate
    do_start(10'd1023, 10'd1023, 1'b0, s);
    chk("sat_micros", int'(bus.rem_micros), 999);
    chk("sat_milis",  int'(bus.rem_milis),  999);
    chk("sat_nanos",  int'(bus.rem_nanos),  0);
    do_cancel();

    // borrow across both fields
    do_start(10'd1, 10'd0, 1'b0, s);
    chk("borrow_load_milis", int'(bus.rem_milis), 1);
    step(1);
    chk("borrow1_milis",  int'(bus.rem_milis),  0);
    chk("borrow1_micros", int'(bus.rem_micros), 999);
    chk("borrow1_nanos",  int'(bus.rem_nanos),  999);
    step(1000);
    chk("borrow2_micros", int'(bus.rem_micros), 998);
    chk("borrow2_nanos",  int'(bus.rem_nanos),  999);
    do_cancel();
`endif

    step(2);
    chk("pending_expected", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
